alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 162 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// ==========================================================================
// alu_arbiter : round-robin front end sequencing two requesters onto a
//               shared combinational ALU (IDLE -> EXEC -> DONE).
// Rev 1.0
// ==========================================================================
module alu_arbiter (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Req0,
  input  logic       Req1,
  input  logic [7:0] InA0,
  input  logic [7:0] InB0,
  input  logic [7:0] InA1,
  input  logic [7:0] InB1,
  input  logic [4:0] Imm0,
  input  logic [4:0] Imm1,
  input  logic [2:0] Op0,
  input  logic [2:0] Op1,
  output logic       Gnt0,
  output logic       Gnt1,
  output logic       Done0,
  output logic       Done1,
  output logic [7:0] Result,
  output logic       ZeroOut,
  output logic       Busy,
  output logic [7:0] AluA,
  output logic [7:0] AluB,
  output logic [4:0] AluImm,
  output logic [2:0] AluOp,
  input  logic [7:0] AluOut,
  input  logic       AluZero
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0] state_q, state_d;

  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic       done0_q, done0_d;
  logic       done1_q, done1_d;
  logic       winner_q, winner_d;
  logic       last_gnt_q, last_gnt_d;
  logic [7:0] opa_q, opa_d;
  logic [7:0] opb_q, opb_d;
  logic [4:0] imm_q, imm_d;
  logic [2:0] op_q, op_d;
  logic [7:0] result_q, result_d;
  logic       zero_q, zero_d;

  logic       any_req;
  logic       pick;

  assign any_req = Req0 | Req1;
  // Contested requests go to whoever was not granted last.
  assign pick    = (Req0 & Req1) ? ~last_gnt_q : Req1;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any_req) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    Busy   = (state_q != ST_IDLE);
    AluA   = 8'd0;
    AluB   = 8'd0;
    AluImm = 5'd0;
    AluOp  = 3'd0;
    if (state_q == ST_EXEC) begin
      AluA   = opa_q;
      AluB   = opb_q;
      AluImm = imm_q;
      AluOp  = op_q;
    end
  end

  always_comb begin
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    winner_d   = winner_q;
    last_gnt_d = last_gnt_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    imm_d      = imm_q;
    op_d       = op_q;
    result_d   = result_q;
    zero_d     = zero_q;
    if (state_q == ST_IDLE && any_req) begin
      winner_d   = pick;
      last_gnt_d = pick;
      gnt0_d     = ~pick;
      gnt1_d     = pick;
      opa_d      = pick ? InA1 : InA0;
      opb_d      = pick ? InB1 : InB0;
      imm_d      = pick ? Imm1 : Imm0;
      op_d       = pick ? Op1  : Op0;
    end
    if (state_q == ST_EXEC) begin
      result_d = AluOut;
      zero_d   = AluZero;
      done0_d  = ~winner_q;
      done1_d  = winner_q;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      winner_q   <= 1'b0;
      last_gnt_q <= 1'b1;
      opa_q      <= 8'd0;
      opb_q      <= 8'd0;
      imm_q      <= 5'd0;
      op_q       <= 3'd0;
      result_q   <= 8'd0;
      zero_q     <= 1'b0;
    end else begin
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      winner_q   <= winner_d;
      last_gnt_q <= last_gnt_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      imm_q      <= imm_d;
      op_q       <= op_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
    end
  end

  assign Gnt0    = gnt0_q;
  assign Gnt1    = gnt1_q;
  assign Done0   = done0_q;
  assign Done1   = done1_q;
  assign Result  = result_q;
  assign ZeroOut = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_alu_arbiter : directed scenarios plus randomized traffic against a
//                  transaction-level model of the arbiter.
// Rev 1.0
// ==========================================================================
module tb_alu_arbiter;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_XOR = 3'd4;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Req0 = 1'b0, Req1 = 1'b0;
  logic [7:0] InA0 = 8'd0, InB0 = 8'd0, InA1 = 8'd0, InB1 = 8'd0;
  logic [4:0] Imm0 = 5'd0, Imm1 = 5'd0;
  logic [2:0] Op0 = 3'd0, Op1 = 3'd0;
  logic       Gnt0, Gnt1, Done0, Done1, ZeroOut, Busy, AluZero;
  logic [7:0] Result, AluA, AluB, AluOut;
  logic [4:0] AluImm;
  logic [2:0] AluOp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  alu_arbiter dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .Req0(Req0), .Req1(Req1),
    .InA0(InA0), .InB0(InB0), .InA1(InA1), .InB1(InB1),
    .Imm0(Imm0), .Imm1(Imm1), .Op0(Op0), .Op1(Op1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .Done0(Done0), .Done1(Done1),
    .Result(Result), .ZeroOut(ZeroOut), .Busy(Busy),
    .AluA(AluA), .AluB(AluB), .AluImm(AluImm), .AluOp(AluOp),
    .AluOut(AluOut), .AluZero(AluZero)
  );

  // Behavioural shared ALU; also the reference for expected results.
  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [4:0] imm, input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << imm[2:0];
      3'd6:    return a + {3'b000, imm};
      default: return b;
    endcase
  endfunction

  assign AluOut  = alu_ref(AluA, AluB, AluImm, AluOp);
  assign AluZero = (AluOut == 8'd0);

  task automatic test_reset;
    Reset_n = 1'b0;
    Req0 = 1'b1;
    Req1 = 1'b0;
    #1;
    n_checks++;
    if ({Busy, Gnt0, Gnt1, Done0, Done1} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000", {Busy, Gnt0, Gnt1, Done0, Done1});
    end
    repeat (2) @(negedge Clk);
    n_checks++;
    if ({Busy, Gnt0, Result, ZeroOut, AluA, AluOp} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_hold: busy=%b gnt0=%b result=%h zero=%b alua=%h aluop=%h want all 0",
               Busy, Gnt0, Result, ZeroOut, AluA, AluOp);
    end
    Req0 = 1'b0;
    Reset_n = 1'b1;
  endtask

  task automatic test_single_op;
    Req0 = 1'b1; Op0 = OP_ADD; InA0 = 8'd20; InB0 = 8'd22; Imm0 = 5'd0;
    @(negedge Clk);
    n_checks++;
    if ({Gnt0, Gnt1, Busy, AluA, AluB, AluOp} !== {3'b101, 8'd20, 8'd22, OP_ADD}) begin
      n_fail++;
      $display("FAIL single_exec: gnt0=%b gnt1=%b busy=%b a=%0d b=%0d op=%0d want 1 0 1 20 22 0",
               Gnt0, Gnt1, Busy, AluA, AluB, AluOp);
    end
    Req0 = 1'b0;
    @(negedge Clk);
    n_checks++;
    if ({Done0, Done1, Gnt0, Result, ZeroOut} !== {3'b100, 8'd42, 1'b0}) begin
      n_fail++;
      $display("FAIL single_done: done0=%b done1=%b gnt0=%b result=%0d zero=%b want 1 0 0 42 0",
               Done0, Done1, Gnt0, Result, ZeroOut);
    end
    @(negedge Clk);
    n_checks++;
    if ({Busy, Done0, AluA, AluB} !== 18'd0) begin
      n_fail++;
      $display("FAIL single_idle: busy=%b done0=%b a=%0d b=%0d want 0 0 0 0", Busy, Done0, AluA, AluB);
    end
  endtask

  task automatic test_contention;
    logic [3:0] exp_v;
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    Req0 = 1'b1; Op0 = OP_ADD; InA0 = 8'd1; InB0 = 8'd1;
    Req1 = 1'b1; Op1 = OP_ADD; InA1 = 8'd2; InB1 = 8'd2;
    for (int c = 1; c <= 8; c++) begin
      @(negedge Clk);
      exp_v = {(c == 1 || c == 7), (c == 4), (c == 2 || c == 8), (c == 5)};
      n_checks++;
      if ({Gnt0, Gnt1, Done0, Done1} !== exp_v) begin
        n_fail++;
        $display("FAIL contention_c%0d: gnt0,gnt1,done0,done1=%b want %b", c,
                 {Gnt0, Gnt1, Done0, Done1}, exp_v);
      end
      if (c == 5) begin
        n_checks++;
        if (Result !== 8'd4) begin
          n_fail++;
          $display("FAIL contention_result1: got %0d want 4", Result);
        end
      end
    end
    Req0 = 1'b0;
    Req1 = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_zero_flag;
    Req1 = 1'b1; Op1 = OP_XOR; InA1 = 8'hA5; InB1 = 8'hA5; Imm1 = 5'd3;
    @(negedge Clk);
    n_checks++;
    if ({Gnt0, Gnt1, AluImm, AluOp} !== {2'b01, 5'd3, OP_XOR}) begin
      n_fail++;
      $display("FAIL zero_exec: gnt0=%b gnt1=%b imm=%0d op=%0d want 0 1 3 4", Gnt0, Gnt1, AluImm, AluOp);
    end
    Req1 = 1'b0;
    @(negedge Clk);
    n_checks++;
    if ({Done0, Done1, Result, ZeroOut} !== {2'b01, 8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL zero_done: done0=%b done1=%b result=%h zero=%b want 0 1 00 1",
               Done0, Done1, Result, ZeroOut);
    end
    @(negedge Clk);
  endtask

  task automatic test_operand_hold;
    Req0 = 1'b1; Op0 = OP_ADD; InA0 = 8'd5; InB0 = 8'd0;
    @(negedge Clk);
    InA0 = 8'd99;
    Req0 = 1'b0;
    #1;
    n_checks++;
    if ({Gnt0, AluA} !== {1'b1, 8'd5}) begin
      n_fail++;
      $display("FAIL hold_exec: gnt0=%b alua=%0d want 1 5", Gnt0, AluA);
    end
    @(negedge Clk);
    n_checks++;
    if ({Done0, Result, ZeroOut} !== {1'b1, 8'd5, 1'b0}) begin
      n_fail++;
      $display("FAIL hold_done: done0=%b result=%0d zero=%b want 1 5 0", Done0, Result, ZeroOut);
    end
    @(negedge Clk);
  endtask

  task automatic test_reset_mid_op;
    Req0 = 1'b1; Op0 = OP_ADD; InA0 = 8'd1; InB0 = 8'd2;
    @(negedge Clk);
    n_checks++;
    if ({Gnt0, Busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL midrst_exec: gnt0=%b busy=%b want 1 1", Gnt0, Busy);
    end
    Reset_n = 1'b0;
    #1;
    n_checks++;
    if ({Busy, Gnt0, Result} !== 10'd0) begin
      n_fail++;
      $display("FAIL midrst_abort: busy=%b gnt0=%b result=%0d want 0 0 0", Busy, Gnt0, Result);
    end
    repeat (2) @(negedge Clk);
    n_checks++;
    if ({Done0, Done1, Busy, Result} !== 11'd0) begin
      n_fail++;
      $display("FAIL midrst_nodone: done0=%b done1=%b busy=%b result=%0d want 0 0 0 0",
               Done0, Done1, Busy, Result);
    end
    Reset_n = 1'b1;
    InA0 = 8'd3; InB0 = 8'd4;
    @(negedge Clk);
    n_checks++;
    if (Gnt0 !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_regnt: gnt0=%b want 1", Gnt0);
    end
    Req0 = 1'b0;
    @(negedge Clk);
    n_checks++;
    if ({Done0, Result} !== {1'b1, 8'd7}) begin
      n_fail++;
      $display("FAIL midrst_redone: done0=%b result=%0d want 1 7", Done0, Result);
    end
    @(negedge Clk);
  endtask

  task automatic test_idle;
    Req0 = 1'b0;
    Req1 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      n_checks++;
      if ({Busy, Gnt0, Gnt1, Done0, Done1, AluA, AluB, AluImm, AluOp} !== 29'd0) begin
        n_fail++;
        $display("FAIL idle_c%0d: busy=%b gnt=%b%b done=%b%b a=%h b=%h imm=%h op=%h want all 0",
                 c, Busy, Gnt0, Gnt1, Done0, Done1, AluA, AluB, AluImm, AluOp);
      end
    end
  endtask

  task automatic rand_ops(input int r);
    logic [7:0] a;
    a = 8'($urandom);
    if (r == 0) begin
      InA0 = a; InB0 = ($urandom_range(7, 0) == 0) ? a : 8'($urandom);
      Imm0 = 5'($urandom); Op0 = 3'($urandom);
    end else begin
      InA1 = a; InB1 = ($urandom_range(7, 0) == 0) ? a : 8'($urandom);
      Imm1 = 5'($urandom); Op1 = 3'($urandom);
    end
  endtask

  // Transaction model: an accepted operation occupies the ALU for three
  // cycles (grant, done, recovery); contested requests alternate.
  task automatic test_random;
    int         m_rem;
    logic       m_win, m_last;
    logic [7:0] m_a, m_b, m_res;
    logic [4:0] m_imm;
    logic [2:0] m_op;
    logic       m_zero;
    logic [1:0] e_gnt, e_done;
    logic [20:0] e_alu;
    Reset_n = 1'b0;
    Req0 = 1'b0;
    Req1 = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    m_rem = 0; m_last = 1'b1; m_win = 1'b0; m_res = 8'd0; m_zero = 1'b0;
    m_a = 8'd0; m_b = 8'd0; m_imm = 5'd0; m_op = 3'd0;
    for (int i = 0; i < 600; i++) begin
      @(negedge Clk);
      e_gnt = 2'b00;
      e_done = 2'b00;
      if (m_rem == 2) begin
        m_rem  = 1;
        m_res  = alu_ref(m_a, m_b, m_imm, m_op);
        m_zero = (m_res == 8'd0);
        e_done[m_win] = 1'b1;
      end else if (m_rem == 1) begin
        m_rem = 0;
      end else if (Req0 || Req1) begin
        m_win  = (Req0 && Req1) ? !m_last : Req1;
        m_last = m_win;
        m_a    = m_win ? InA1 : InA0;
        m_b    = m_win ? InB1 : InB0;
        m_imm  = m_win ? Imm1 : Imm0;
        m_op   = m_win ? Op1  : Op0;
        e_gnt[m_win] = 1'b1;
        m_rem  = 2;
      end
      e_alu = (m_rem == 2) ? {m_a, m_b, m_imm} : 21'd0;
      n_checks++;
      if ({Gnt1, Gnt0} !== e_gnt) begin
        n_fail++;
        $display("FAIL rand_gnt@%0d: got %b want %b", i, {Gnt1, Gnt0}, e_gnt);
      end
      n_checks++;
      if ({Done1, Done0} !== e_done) begin
        n_fail++;
        $display("FAIL rand_done@%0d: got %b want %b", i, {Done1, Done0}, e_done);
      end
      n_checks++;
      if (Busy !== (m_rem != 0)) begin
        n_fail++;
        $display("FAIL rand_busy@%0d: got %b want %b", i, Busy, (m_rem != 0));
      end
      n_checks++;
      if ({Result, ZeroOut} !== {m_res, m_zero}) begin
        n_fail++;
        $display("FAIL rand_result@%0d: got %h/%b want %h/%b", i, Result, ZeroOut, m_res, m_zero);
      end
      n_checks++;
      if ({AluA, AluB, AluImm, AluOp} !== {e_alu, (m_rem == 2) ? m_op : 3'd0}) begin
        n_fail++;
        $display("FAIL rand_alubus@%0d: got %h %h %h %h want %h op %h", i, AluA, AluB, AluImm,
                 AluOp, e_alu, (m_rem == 2) ? m_op : 3'd0);
      end
      if (Req0 && e_gnt[0]) begin
        rand_ops(0);
        Req0 = 1'($urandom_range(1, 0));
      end else if (!Req0 && $urandom_range(2, 0) == 0) begin
        rand_ops(0);
        Req0 = 1'b1;
      end
      if (Req1 && e_gnt[1]) begin
        rand_ops(1);
        Req1 = 1'($urandom_range(1, 0));
      end else if (!Req1 && $urandom_range(2, 0) == 0) begin
        rand_ops(1);
        Req1 = 1'b1;
      end
    end
    Req0 = 1'b0;
    Req1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_contention();
    test_zero_flag();
    test_operand_hold();
    test_reset_mid_op();
    test_idle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
